nibble_serial_alu: RTL and testbench

NIBBLE_SERIAL_ALU -- requirements
Module: nibble_serial_alu

---
 rtl/alu_serial_pkg.sv | 17 +
 rtl/alu_nibble.sv | 37 +++
 rtl/nibble_serial_alu.sv | 120 ++++++++++++
 tb/tb_nibble_serial_alu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_pkg.sv
// rtl/alu_serial_pkg.sv - shared op and state encodings for the nibble-serial ALU
package alu_serial_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_nibble.sv
// rtl/alu_nibble.sv - combinational 4-bit add/sub/xor/xnor slice with carry-in
module alu_nibble
  import alu_serial_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  op_t        op,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] bx;
  logic [3:0] lo;
  logic [1:0] hi;

  // Split the add at bit 3 so the carry into the slice MSB is visible for overflow.
  always_comb begin
    bx   = (op == OP_SUB) ? ~b : b;
    lo   = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
    hi   = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, lo[3]};
    s    = 4'h0;
    cout = 1'b0;
    c3   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        s    = {hi[0], lo[2:0]};
        cout = hi[1];
        c3   = lo[3];
      end
      OP_XOR:  s = a ^ b;
      default: s = ~(a ^ b);
    endcase
  end

endmodule

// File: rtl/nibble_serial_alu.sv
// rtl/nibble_serial_alu.sv - nibble-serial ALU: one 4-bit slice per cycle, LSB first
// Optional signed-overflow flag enabled by defining ALU_SERIAL_OVF_EN.
module nibble_serial_alu #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic [1:0]             in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_s,
  output logic                   out_cout,
  output logic                   out_zero,
  output logic                   out_ovf
);
  import alu_serial_pkg::*;

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);

  state_t          state;
  op_t             op_r;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    s_sh;
  logic [IW-1:0]   idx;
  logic            carry;

  logic [3:0]      nib_s;
  logic            nib_cout;
  logic            nib_c3;

  alu_nibble u_nibble (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .op   (op_r),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout),
    .c3   (nib_c3)
  );

  assign in_ready = (state == IDLE);
  assign out_s    = s_sh;

`ifdef ALU_SERIAL_OVF_EN
  logic msb_cin;
  logic ovf_r;
  assign out_ovf = ovf_r;
`else
  logic unused_nib_c3;
  assign unused_nib_c3 = nib_c3;
  assign out_ovf       = 1'b0;
`endif

  // RUN spends NIBBLES cycles on slices, then one finalize cycle that latches the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= OP_ADD;
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      out_cout  <= 1'b0;
      out_zero  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      msb_cin   <= 1'b0;
      ovf_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            op_r  <= op_t'(in_op);
            carry <= (op_t'(in_op) == OP_SUB);
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (idx == IW'(NIBBLES)) begin
            out_valid <= 1'b1;
            out_cout  <= carry;
            out_zero  <= (s_sh == '0);
`ifdef ALU_SERIAL_OVF_EN
            ovf_r     <= ((op_r == OP_ADD) || (op_r == OP_SUB)) && (msb_cin ^ carry);
`endif
            state     <= DONE;
          end else begin
            s_sh  <= {nib_s, s_sh[W-1:4]};
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            carry <= nib_cout;
`ifdef ALU_SERIAL_OVF_EN
            msb_cin <= nib_c3;
`endif
            idx   <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu.sv
// tb/tb_nibble_serial_alu.sv - self-checking bench for nibble_serial_alu
module tb_nibble_serial_alu;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
`ifdef ALU_SERIAL_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_cout;
  logic         out_zero;
  logic         out_ovf;

  int errors;
  int checks;

  nibble_serial_alu #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] s;
    logic        c;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, overflow from operand/result sign rules.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                                    output logic [15:0] s, output logic c, output logic z,
                                    output logic o);
    logic [16:0] full;
    s = 16'h0; c = 1'b0; o = 1'b0;
    case (op)
      2'b00: begin
        full = {1'b0, a} + {1'b0, b};
        s = full[15:0];
        c = full[16];
        o = (a[15] == b[15]) && (s[15] != a[15]);
      end
      2'b01: begin
        s = a - b;
        c = (a >= b);
        o = (a[15] != b[15]) && (s[15] != a[15]);
      end
      2'b10:   s = a ^ b;
      default: s = ~(a ^ b);
    endcase
    z = (s == 16'h0);
    o = o & OVF_ON;
  endfunction

  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         output logic [15:0] s, output logic c, output logic z, output logic o,
                         output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    s = out_s; c = out_cout; z = out_zero; o = out_ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] s, es;
    logic        c, z, o, ec, ez, eo;
    logic [15:0] ra, rb;
    logic [1:0]  rop;
    int          lat;

    errors = 0;
    checks = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; out_ready = 1'b0;

    vecs[0]  = '{16'h1234, 16'h0FFF, 2'b00, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0007, 2'b01, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'h7FFF, 2'b01, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{16'h8000, 16'h8000, 2'b00, 16'h0000, 1'b1, 1'b1, OVF_ON};
    vecs[4]  = '{16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, 1'b0, OVF_ON};
    vecs[5]  = '{16'hF0F0, 16'hFF00, 2'b10, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'hF0F0, 16'hFF00, 2'b11, 16'hF00F, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'hAAAA, 16'hAAAA, 2'b10, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b1, 1'b0, OVF_ON};
    vecs[10] = '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_s", out_s, 0);
    check("reset_flags", {out_cout, out_zero, out_ovf}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, s, c, z, o, lat);
      check($sformatf("vec%0d_s", i), s, vecs[i].s);
      check($sformatf("vec%0d_cout", i), c, vecs[i].c);
      check($sformatf("vec%0d_zero", i), z, vecs[i].z);
      check($sformatf("vec%0d_ovf", i), o, vecs[i].o);
      check($sformatf("vec%0d_latency", i), lat, NIBBLES + 1);
    end

    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 2'($urandom_range(0, 3));
      ref_model(ra, rb, rop, es, ec, ez, eo);
      run_cmd(ra, rb, rop, s, c, z, o, lat);
      check($sformatf("rand%0d_s", i), s, es);
      check($sformatf("rand%0d_flags", i), {c, z, o}, {ec, ez, eo});
    end

    // Backpressure with in_valid held high through RUN and DONE.
    in_a = 16'h1111; in_b = 16'h2222; in_op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_op = 2'b01;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_latency", lat, NIBBLES + 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", k), out_valid, 1);
      check($sformatf("bp_hold%0d_s", k), out_s, 16'h3333);
      check($sformatf("bp_hold%0d_flags", k), {out_cout, out_zero, out_ovf}, 0);
      check($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Reset asserted while slice 2 is being processed.
    run_cmd(16'h8000, 16'h8000, 2'b00, s, c, z, o, lat);
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_s", out_s, 0);
    check("midrst_flags", {out_cout, out_zero, out_ovf}, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(16'h1234, 16'h0FFF, 2'b00, s, c, z, o, lat);
    check("postrst_s", s, 16'h2233);
    check("postrst_flags", {c, z, o}, 0);
    check("postrst_latency", lat, NIBBLES + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
